piso_serializer: RTL
====================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits, legal range 2..32.
REQ-002 Parameter DIV, default 1: clocks per serial bit, legal range 1..256.
REQ-003 Parameter IDLE_LEVEL, default 1'b0: level driven on dout when no bit is being sent.
REQ-004 Port clk, input, 1: clock; all state updates on rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-high.
REQ-006 Port clear, input, 1: synchronous abort, active-high.
REQ-007 Port din, input, WIDTH: parallel word to transmit.
REQ-008 Port msb_first, input, 1: bit order; 1 = MSB first, 0 = LSB first.
REQ-009 Port din_valid, input, 1: din and msb_first are valid.
REQ-010 Port din_ready, output, 1: block accepts a word this cycle.
REQ-011 Port dout, output, 1: serial data out.
REQ-012 Port dout_valid, output, 1: dout carries a frame bit.
REQ-013 Port frame_start, output, 1: one-clock pulse in the first cycle of bit 0 of a frame.
REQ-014 Port frame_done, output, 1: one-clock pulse in the last cycle of the last bit of a frame.
REQ-015 Port busy, output, 1: high while the FSM is in SHIFT.

Function
REQ-016 The FSM SHALL have two states: IDLE and SHIFT.
REQ-017 Handshake: a word SHALL be accepted on a rising edge where din_valid=1, din_ready=1 and clear=0.
REQ-018 din_ready SHALL be 1 in IDLE, and in SHIFT during the final clock of the final bit; it SHALL be 0 otherwise and whenever clear=1.
REQ-019 On acceptance, the block SHALL latch din and msb_first into internal registers, load the bit counter with WIDTH-1, load the divider with DIV-1, and enter or remain in SHIFT.
REQ-020 Latency: the first bit SHALL appear on dout in the clock after the acceptance edge.
REQ-021 Each bit SHALL be held on dout for exactly DIV clocks, so a frame lasts WIDTH*DIV clocks.
REQ-022 Bit order: with msb_first=1, bits SHALL be sent din[WIDTH-1] down to din[0]; with msb_first=0, din[0] up to din[WIDTH-1].
REQ-023 Changes on din or msb_first after acceptance SHALL NOT affect the frame in flight.
REQ-024 In SHIFT: dout_valid=1 and busy=1. In IDLE: dout_valid=0, busy=0 and dout=IDLE_LEVEL.
REQ-025 At the end of the last bit, with no new acceptance, the FSM SHALL return to IDLE on that edge.
REQ-026 Back-to-back: if a word is accepted at the end of the last bit, the FSM SHALL stay in SHIFT and bit 0 of the new frame SHALL follow with zero gap.
REQ-027 On a back-to-back transfer, frame_done (old frame) and frame_start (new frame) SHALL each pulse in their own adjacent cycles.
REQ-028 Counters SHALL NOT wrap: the bit counter goes from WIDTH-1 to 0, and the divider goes from DIV-1 to 0 and reloads per bit.
REQ-029 When DIV=1, the divider SHALL be bypassed and one bit SHALL be sent per clock.
REQ-030 clear=1 SHALL force IDLE on the next edge, drop dout_valid and busy, drive dout to IDLE_LEVEL, and suppress frame_done; the aborted frame SHALL be discarded.
REQ-031 clear SHALL take priority over a simultaneous din_valid.

Reset
REQ-032 While rst=1, the block SHALL be in IDLE with dout=IDLE_LEVEL, dout_valid=0, busy=0, frame_start=0, frame_done=0 and din_ready=0. All internal registers SHALL be cleared to 0.
REQ-033 The first edge after rst deasserts SHALL bring din_ready=1.
REQ-034 rst asserted mid-frame SHALL abort immediately and asynchronously; no frame_done SHALL be produced.

Verification
REQ-035 WIDTH=8, DIV=1, din=8'hA5, msb_first=1 -> dout sequence 1,0,1,0,0,1,0,1 in 8 clocks; frame_start in cycle 1; frame_done in cycle 8.
REQ-036 Same word with msb_first=0 -> dout sequence 1,0,1,0,0,1,0,1 reversed by index (din[0] first), i.e. 1,0,1,0,0,1,0,1; repeat with 8'h01 -> 1,0,0,0,0,0,0,0.
REQ-037 DIV=3, din=8'hF0, msb_first=1 -> each bit held 3 clocks, 24 clocks total, din_ready=0 throughout except the final clock.
REQ-038 Back-to-back 8'h0F then 8'hFF with din_valid held high -> 16 contiguous dout_valid cycles; frame_done in cycle 8, frame_start in cycle 9.
REQ-039 clear pulsed at bit 3 of 8'h55 -> next cycle dout=IDLE_LEVEL, dout_valid=0, no frame_done, din_ready=1.
REQ-040 rst asserted mid-frame -> outputs take reset values immediately; after release, a new word 8'h81 transmits correctly.

Source files
------------

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out shifter. A WIDTH-bit word is accepted through a
// valid/ready handshake and sent on dout one bit at a time. Each bit is held
// for DIV clocks, and the bit order is chosen per word with msb_first.
//
// Handshake (valid/ready): a word transfers on a rising edge where
//   din_valid=1 && din_ready=1 (din_ready already includes clear=0).
//   din_valid/din/msb_first may change freely when no transfer happens;
//   din_ready never depends on din_valid.
//
// Parameters
//   WIDTH      : parallel word width, 2..32
//   DIV        : clocks per serial bit, 1..256
//   IDLE_LEVEL : level on dout while no frame bit is being sent
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   clear       : synchronous abort of the frame in flight
//   din         : parallel word
//   msb_first   : 1 = send din[WIDTH-1] first, 0 = send din[0] first
//   din_valid   : din/msb_first valid
//   din_ready   : a word can be accepted this cycle
//   dout        : serial data
//   dout_valid  : dout carries a frame bit
//   frame_start : pulse in the first clock of bit 0
//   frame_done  : pulse in the last clock of the last bit
//   busy        : FSM is in SHIFT (this is the FSM state as seen outside)
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int   WIDTH      = 8,
  parameter int   DIV        = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             msb_first,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               msb_q, msb_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               frame_start_q, frame_start_d;
  // Goes high on the first edge after reset; keeps din_ready low in reset
  // and for the first cycle after release.
  logic               live_q, live_d;

  logic               bit_end;
  logic               last_clk;
  logic               accept;
  logic [CNT_W-1:0]   bit_idx;

  always_comb begin
    // With DIV=1 the divider is bypassed: every clock ends a bit.
    bit_end   = (DIV == 1) ? 1'b1 : (div_cnt_q == '0);
    last_clk  = (state_q == SHIFT) && (bit_cnt_q == '0) && bit_end;
    din_ready = live_q && !clear && ((state_q == IDLE) || last_clk);
    accept    = din_valid && din_ready;

    // bit_cnt counts down from WIDTH-1, so it is the MSB-first index
    // directly; LSB-first mirrors it.
    bit_idx   = msb_q ? bit_cnt_q : (BIT_LAST - bit_cnt_q);

    dout        = (state_q == SHIFT) ? data_q[bit_idx] : IDLE_LEVEL;
    dout_valid  = (state_q == SHIFT);
    busy        = (state_q == SHIFT);
    frame_start = frame_start_q;
    // An aborted final clock must not report completion.
    frame_done  = last_clk && !clear;
  end

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    msb_d         = msb_q;
    bit_cnt_d     = bit_cnt_q;
    div_cnt_d     = div_cnt_q;
    frame_start_d = accept;
    live_d        = 1'b1;

    if (clear) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      div_cnt_d = '0;
    end else if (accept) begin
      // Also covers the back-to-back case: the final clock of the old frame
      // reloads directly, so the new bit 0 follows with no gap.
      state_d   = SHIFT;
      data_d    = din;
      msb_d     = msb_first;
      bit_cnt_d = BIT_LAST;
      div_cnt_d = DIV_LAST;
    end else if (state_q == SHIFT) begin
      if (bit_end) begin
        if (bit_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
          div_cnt_d = DIV_LAST;
        end
      end else begin
        div_cnt_d = div_cnt_q - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      data_q        <= '0;
      msb_q         <= 1'b0;
      bit_cnt_q     <= '0;
      div_cnt_q     <= '0;
      frame_start_q <= 1'b0;
      live_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      msb_q         <= msb_d;
      bit_cnt_q     <= bit_cnt_d;
      div_cnt_q     <= div_cnt_d;
      frame_start_q <= frame_start_d;
      live_q        <= live_d;
    end
  end

endmodule
